key_sequencer: RTL

Record/playback controller for the 48-key note path. In record mode it samples the live key vector once per tick, run-length encodes it into an internal note memory as (note, duration) entries, and flushes the final segment on stop. In playback mode it drives a one-hot key vector into the key-to-frequency decoder, re-creating the recorded melody with tick-exact durations. It sits between the keyboard scanner and the frequency decoder.

---
 rtl/key_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/key_sequencer.sv
// key_sequencer: record/playback of run-length encoded key presses.
// Records (note, duration) entries per tick and replays them one-hot.
module key_sequencer #(
   parameter int KEYS     = 48,
   parameter int DEPTH    = 256,
   parameter int TICK_DIV = 50000,
   parameter int DUR_W    = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [KEYS-1:0]        key_in,
   input  logic                   rec_start,
   input  logic                   play_start,
   input  logic                   stop,
   output logic [KEYS-1:0]        key_out,
   output logic                   busy,
   output logic                   rec_full,
   output logic                   play_done,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TICK_DIV);
   localparam int EW = 6 + DUR_W;
   localparam logic [5:0]       REST = 6'd63;
   localparam logic [DUR_W-1:0] DMAX = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_REC, S_FLUSH, S_LOAD, S_PLAY
   } state_e;

   state_e           state_q;
   logic [TW-1:0]    tick_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    rd_ptr_q;
   logic [5:0]       cur_q;
   logic [DUR_W-1:0] dur_q;
   logic [DUR_W-1:0] rem_q;
   logic [KEYS-1:0]  key_out_q;
   logic             busy_q;
   logic             rec_full_q;
   logic             play_done_q;
   logic [EW-1:0]    mem_q [DEPTH];
   logic [EW-1:0]    nxt_q;

   logic             tick;
   logic [5:0]       note;
   logic             we;
   logic [AW-1:0]    raddr;
   logic [CW-1:0]    count_inc;

   function automatic logic [5:0] enc(input logic [KEYS-1:0] k);
      enc = REST;
      for (int i = KEYS - 1; i >= 0; i--)
         if (k[i]) enc = 6'(i);
   endfunction

   function automatic logic [KEYS-1:0] dec(input logic [5:0] n);
      for (int i = 0; i < KEYS; i++)
         dec[i] = (n == 6'(i));
   endfunction

   always_comb begin
      tick      = (tick_q == TW'(TICK_DIV - 1));
      note      = enc(key_in);
      count_inc = count_q + CW'(1);
      we        = 1'b0;
      if (state_q == S_REC && !stop && tick && dur_q != '0 &&
          (note != cur_q || dur_q == DMAX))
         we = 1'b1;
      if (state_q == S_FLUSH && dur_q != '0 && count_q < CW'(DEPTH))
         we = 1'b1;
      // Address 0 while idle so the first entry is ready for LOAD
      raddr = (state_q == S_IDLE) ? '0 : rd_ptr_q[AW-1:0];
   end

   always_ff @(posedge clk) begin
      if (we) mem_q[count_q[AW-1:0]] <= {cur_q, dur_q};
      nxt_q <= mem_q[raddr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         tick_q      <= '0;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         cur_q       <= REST;
         dur_q       <= '0;
         rem_q       <= '0;
         key_out_q   <= '0;
         busy_q      <= 1'b0;
         rec_full_q  <= 1'b0;
         play_done_q <= 1'b0;
      end else begin
         play_done_q <= 1'b0;
         tick_q      <= tick ? '0 : tick_q + TW'(1);
         if (we) count_q <= count_inc;
         unique case (state_q)
            S_IDLE: begin
               if (rec_start) begin
                  state_q    <= S_REC;
                  busy_q     <= 1'b1;
                  count_q    <= '0;
                  rec_full_q <= 1'b0;
                  tick_q     <= '0;
                  dur_q      <= '0;
               end else if (play_start) begin
                  if (count_q != '0) begin
                     state_q <= S_LOAD;
                     busy_q  <= 1'b1;
                  end else begin
                     play_done_q <= 1'b1;
                  end
               end
            end
            S_REC: begin
               if (stop) begin
                  state_q <= S_FLUSH;
               end else if (tick) begin
                  if (we) begin
                     cur_q <= note;
                     dur_q <= DUR_W'(1);
                     if (count_inc == CW'(DEPTH)) begin
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                        rec_full_q <= 1'b1;
                     end
                  end else if (dur_q == '0) begin
                     cur_q <= note;
                     dur_q <= DUR_W'(1);
                  end else begin
                     dur_q <= dur_q + DUR_W'(1);
                  end
               end
            end
            S_FLUSH: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               dur_q   <= '0;
            end
            S_LOAD: begin
               state_q   <= S_PLAY;
               tick_q    <= '0;
               key_out_q <= dec(nxt_q[EW-1 -: 6]);
               rem_q     <= nxt_q[DUR_W-1:0];
               rd_ptr_q  <= CW'(1);
            end
            S_PLAY: begin
               if (stop) begin
                  key_out_q <= '0;
                  state_q   <= S_IDLE;
                  busy_q    <= 1'b0;
               end else if (tick) begin
                  if (rem_q != DUR_W'(1)) begin
                     rem_q <= rem_q - DUR_W'(1);
                  end else if (rd_ptr_q == count_q) begin
                     key_out_q   <= '0;
                     play_done_q <= 1'b1;
                     state_q     <= S_IDLE;
                     busy_q      <= 1'b0;
                  end else begin
                     key_out_q <= dec(nxt_q[EW-1 -: 6]);
                     rem_q     <= nxt_q[DUR_W-1:0];
                     rd_ptr_q  <= rd_ptr_q + CW'(1);
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign key_out   = key_out_q;
   assign busy      = busy_q;
   assign rec_full  = rec_full_q;
   assign play_done = play_done_q;
   assign count     = count_q;

endmodule
